// File: rtl/pip_pkg.sv
// Shared types and defaults for the EX-stage hazard controller and MDU busy timer.
// No logic here.
package pip_pkg;

  localparam int REGW            = 5;
  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int CNTW            = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  // Control fields held in ID/EX; all-zero forms a bubble.
  typedef struct packed {
    logic       alu_alt_src;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_ZERO_CTRL = '0;

  // Counter load value: busy window length minus one, so cnt==0 marks the final busy cycle.
  function automatic logic [CNTW-1:0] mdu_len_m1(input logic div, input int mult_c, input int div_c);
    return div ? CNTW'(div_c - 1) : CNTW'(mult_c - 1);
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Loadable 8-bit down-counter timing the MDU busy window; done on the final busy cycle.
// Loads only while idle; a load request while active is dropped and flagged via ignored.
module mdu_busy_timer
  import pip_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  output logic            busy,
  output logic            done,
  output logic            ignored
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load && !active) begin
      cnt <= load_val;
    end else if (active && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy    = active;
  assign done    = active && (cnt == '0);
  assign ignored = load && active;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: zero-latency PC/IF/ID/ID-EX enables and flushes, plus MDU busy sequencing.
// Stalls hold PC and IF/ID and inject an ID/EX bubble; a taken branch overrides any stall.
module ex_hazard_ctrl
  import pip_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int REGW        = pip_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            id_hilo_use,
  input  logic            ex_memread,
  input  logic            ex_regwrite,
  input  logic [REGW-1:0] ex_dst,
  input  logic            ex_mdu_start,
  input  logic            ex_mdu_div,
  input  logic            branch_taken,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic            proto_err,
  output logic [15:0]     stall_cycles
);

  state_t state_q, state_d;
  logic   load_hz, mdu_hz, stall;
  logic   tmr_done, tmr_ignored;

  mdu_busy_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (state_q == MDU_BUSY),
    .load     (ex_mdu_start),
    .load_val (mdu_len_m1(ex_mdu_div, MULT_CYCLES, DIV_CYCLES)),
    .busy     (mdu_busy),
    .done     (tmr_done),
    .ignored  (tmr_ignored)
  );

  assign mdu_done = tmr_done;

  // $zero is never a real producer, so it cannot create a load-use dependency.
  assign load_hz = id_valid && ex_memread && ex_regwrite && (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mdu_hz  = id_valid && id_hilo_use && mdu_busy;
  assign stall   = (load_hz || mdu_hz) && !branch_taken;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (ex_mdu_start) state_d = MDU_BUSY;
      MDU_BUSY: if (tmr_done)     state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (tmr_ignored) proto_err <= 1'b1;
      if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: per-cycle model comparison plus directed literal checks.
module tb_ex_hazard_ctrl;

  localparam int MULT_C = 4;
  localparam int DIV_C  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_uses_rt = 1'b0, id_hilo_use = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0;
  logic       ex_memread = 1'b0, ex_regwrite = 1'b0, ex_mdu_start = 1'b0, ex_mdu_div = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, mdu_busy, mdu_done, proto_err;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  ex_hazard_ctrl #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_hilo_use(id_hilo_use), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_dst(ex_dst), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .branch_taken(branch_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .proto_err(proto_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles of the MDU, sticky protocol error, stall tally.
  int busy_left = 0;
  bit m_perr    = 1'b0;
  int m_stalls  = 0;
  bit st;

  function automatic bit m_stall();
    bit lh, mh;
    lh = id_valid && ex_memread && ex_regwrite && ex_dst != 0 &&
         (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
    mh = id_valid && id_hilo_use && busy_left > 0;
    return (lh || mh) && !branch_taken;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left = 0;
      m_perr    = 1'b0;
      m_stalls  = 0;
    end else begin
      st = m_stall();
      if (st && m_stalls < 65535) m_stalls++;
      if (busy_left > 0) begin
        if (ex_mdu_start) m_perr = 1'b1;
        busy_left--;
      end else if (ex_mdu_start) begin
        busy_left = ex_mdu_div ? DIV_C : MULT_C;
      end
    end
  end

  always @(negedge clk) begin
    bit s, e_pc, e_ff, e_xf;
    s    = m_stall();
    e_pc = rst_n && (branch_taken || !s);
    e_ff = !rst_n || branch_taken;
    e_xf = !rst_n || branch_taken || s;
    check("pc_we",        32'(pc_we),        32'(e_pc));
    check("ifid_we",      32'(ifid_we),      32'(e_pc));
    check("ifid_flush",   32'(ifid_flush),   32'(e_ff));
    check("idex_flush",   32'(idex_flush),   32'(e_xf));
    check("mdu_busy",     32'(mdu_busy),     32'(busy_left > 0));
    check("mdu_done",     32'(mdu_done),     32'(busy_left == 1));
    check("proto_err",    32'(proto_err),    32'(m_perr));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rt = 0; id_hilo_use = 0; id_rs = 0; id_rt = 0;
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0; ex_mdu_start = 0; ex_mdu_div = 0;
    branch_taken = 0;
  endtask

  initial begin
    int nbusy, done_idx, s0;
    logic stalled_all;

    idle();
    #12;
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_ifid_flush", 32'(ifid_flush), 32'd1);
    check("rst_idex_flush", 32'(idex_flush), 32'd1);
    check("rst_busy", 32'(mdu_busy), 32'd0);
    cyc();
    rst_n = 1;
    cyc();

    // Load-use on rs: one stall cycle.
    id_valid = 1; id_rs = 8; ex_memread = 1; ex_regwrite = 1; ex_dst = 8;
    #1;
    check("lu_pc_we", 32'(pc_we), 32'd0);
    check("lu_idex_flush", 32'(idex_flush), 32'd1);
    cyc();
    ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
    #1;
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    check("lu_next_pc_we", 32'(pc_we), 32'd1);
    cyc();

    // $zero and unused rt never stall; used rt does.
    id_rs = 0; ex_memread = 1; ex_regwrite = 1; ex_dst = 0;
    #1;
    check("zero_no_stall", 32'(pc_we), 32'd1);
    cyc();
    id_rs = 3; id_rt = 9; id_uses_rt = 0; ex_dst = 9;
    #1;
    check("rt_unused_no_stall", 32'(pc_we), 32'd1);
    cyc();
    id_uses_rt = 1;
    #1;
    check("rt_used_stall", 32'(pc_we), 32'd0);
    cyc();
    idle();
    cyc();

    // Multiply: 4 busy cycles, HI/LO user held for all of them.
    s0 = stall_cycles;
    ex_mdu_start = 1; ex_mdu_div = 0;
    cyc();
    idle();
    id_valid = 1; id_hilo_use = 1;
    nbusy = 0; done_idx = -1; stalled_all = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mdu_busy) begin
        if (mdu_done) done_idx = nbusy;
        if (pc_we) stalled_all = 0;
        nbusy++;
      end
      cyc();
    end
    check("mul_busy_len", 32'(nbusy), 32'd4);
    check("mul_done_idx", 32'(done_idx), 32'd3);
    check("mul_stalled_all", 32'(stalled_all), 32'd1);
    check("mul_stall_delta", 32'(stall_cycles - 16'(s0)), 32'd4);
    idle();
    cyc();

    // Divide with a branch on busy cycle 3.
    ex_mdu_start = 1; ex_mdu_div = 1;
    cyc();
    idle();
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      branch_taken = (mdu_busy && nbusy == 2);
      #1;
      if (branch_taken) begin
        check("div_br_pc_we", 32'(pc_we), 32'd1);
        check("div_br_ifid_flush", 32'(ifid_flush), 32'd1);
        check("div_br_idex_flush", 32'(idex_flush), 32'd1);
      end
      if (mdu_busy) nbusy++;
      cyc();
    end
    branch_taken = 0;
    check("div_busy_len", 32'(nbusy), 32'd32);
    check("div_proto_err", 32'(proto_err), 32'd0);

    // Branch beats load-use.
    s0 = stall_cycles;
    id_valid = 1; id_rs = 12; ex_memread = 1; ex_regwrite = 1; ex_dst = 12; branch_taken = 1;
    #1;
    check("brlu_pc_we", 32'(pc_we), 32'd1);
    check("brlu_ifid_flush", 32'(ifid_flush), 32'd1);
    check("brlu_idex_flush", 32'(idex_flush), 32'd1);
    cyc();
    idle();
    check("brlu_stall_same", 32'(stall_cycles), 32'(s0));
    cyc();

    // Start while busy: flagged, window length unchanged.
    ex_mdu_start = 1; ex_mdu_div = 0;
    cyc();
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      ex_mdu_start = (i == 1);
      #1;
      if (mdu_busy) nbusy++;
      cyc();
    end
    idle();
    check("perr_busy_len", 32'(nbusy), 32'd4);
    check("perr_set", 32'(proto_err), 32'd1);

    // Reset mid-divide.
    ex_mdu_start = 1; ex_mdu_div = 1;
    cyc();
    idle();
    repeat (5) cyc();
    rst_n = 0;
    #1;
    check("rst_mid_busy", 32'(mdu_busy), 32'd0);
    check("rst_mid_done", 32'(mdu_done), 32'd0);
    check("rst_mid_perr", 32'(proto_err), 32'd0);
    check("rst_mid_stalls", 32'(stall_cycles), 32'd0);
    cyc();
    rst_n = 1;
    repeat (3) cyc();
    check("post_rst_busy", 32'(mdu_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
